// File: rtl/hex_pixel_fetch_scheduler.sv
// Fetches the 14 hexagon pixels (7 current-frame, 7 reference-frame) for one SAD step from a shared,
// arbitrated frame memory. Optional HEX_FETCH_CF_CACHE_EN reuses the cf pixels when the cf coordinates repeat.
module hex_pixel_fetch_scheduler #(
    parameter int FRAME_W = 96,
    parameter int RD_LAT  = 2,
    parameter int RF_BASE = 9216
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [48:0] cf_x_bus,
    input  logic [48:0] cf_y_bus,
    input  logic [48:0] rf_x_bus,
    input  logic [48:0] rf_y_bus,
    output logic        busy,
    output logic        done,
    output logic [55:0] cf_pix_bus,
    output logic [55:0] rf_pix_bus,
    output logic [13:0] oob_mask,
    output logic        mem_rd,
    output logic [14:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [7:0]  FW8   = 8'(FRAME_W);
    localparam logic [14:0] FW15  = 15'(FRAME_W);
    localparam logic [14:0] RFB15 = 15'(RF_BASE);

    state_t      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [6:0]  x_q [14];
    logic [6:0]  y_q [14];
    logic [13:0] oob_q;
    logic [7:0]  pix_q [14];
    logic        tag_v_q [RD_LAT];
    logic [3:0]  tag_s_q [RD_LAT];

    logic        accept;
    logic        cache_hit;
    logic [6:0]  pt_x, pt_y;
    logic        pt_oob;
    logic [14:0] pt_addr;
    logic        issue;
    logic        pend;

    assign accept  = (state_q == IDLE) && req;
    assign pt_x    = x_q[slot_q];
    assign pt_y    = y_q[slot_q];
    assign pt_oob  = ({1'b0, pt_x} >= FW8) || ({1'b0, pt_y} >= FW8);
    assign pt_addr = {8'd0, pt_y} * FW15 + {8'd0, pt_x} + ((slot_q >= 4'd7) ? RFB15 : 15'd0);

`ifdef HEX_FETCH_CF_CACHE_EN
    logic [48:0] cache_x_q, cache_y_q;
    logic        cache_vld_q;

    assign cache_hit = cache_vld_q && (cf_x_bus == cache_x_q) && (cf_y_bus == cache_y_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
        end else if (state_q == DONE) begin
            cache_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DONE) begin
            for (int i = 0; i < 7; i++) begin
                cache_x_q[7*i +: 7] <= x_q[i];
                cache_y_q[7*i +: 7] <= y_q[i];
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        mem_rd   = 1'b0;
        mem_addr = 15'd0;
        issue    = 1'b0;
        pend     = 1'b0;
        // Only entries that survive this edge keep us in DRAIN; the last stage retires now.
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pend = pend | tag_v_q[i];
        end
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ISSUE;
                    slot_d  = cache_hit ? 4'd7 : 4'd0;
                end
            end
            ISSUE: begin
                if (!pt_oob) begin
                    mem_rd   = 1'b1;
                    mem_addr = pt_addr;
                    issue    = mem_gnt;
                end
                if (pt_oob || mem_gnt) begin
                    slot_d = slot_q + 4'd1;
                    if (slot_q == 4'd13) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pend) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 4'd0;
            oob_q   <= 14'd0;
            for (int i = 0; i < 14; i++) begin
                pix_q[i] <= 8'd0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (accept) begin
                oob_q <= cache_hit ? {7'd0, oob_q[6:0]} : 14'd0;
            end
            if ((state_q == ISSUE) && pt_oob) begin
                oob_q[slot_q] <= 1'b1;
                pix_q[slot_q] <= 8'd0;
            end
            tag_v_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
            end
            if (tag_v_q[RD_LAT-1]) begin
                pix_q[tag_s_q[RD_LAT-1]] <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_s_q[0] <= slot_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_s_q[i] <= tag_s_q[i-1];
        end
        if (accept) begin
            for (int i = 0; i < 7; i++) begin
                x_q[i]     <= cf_x_bus[7*i +: 7];
                y_q[i]     <= cf_y_bus[7*i +: 7];
                x_q[i + 7] <= rf_x_bus[7*i +: 7];
                y_q[i + 7] <= rf_y_bus[7*i +: 7];
            end
        end
    end

    assign oob_mask = oob_q;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_pix
            assign cf_pix_bus[8*gi +: 8] = pix_q[gi];
            assign rf_pix_bus[8*gi +: 8] = pix_q[gi + 7];
        end
    endgenerate

endmodule

// File: tb/tb_hex_pixel_fetch_scheduler.sv
// Directed bench for hex_pixel_fetch_scheduler with a fixed-latency memory model whose word is addr[7:0].
module tb_hex_pixel_fetch_scheduler;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [48:0] cf_x_bus, cf_y_bus, rf_x_bus, rf_y_bus;
    logic        busy, done;
    logic [55:0] cf_pix_bus, rf_pix_bus;
    logic [13:0] oob_mask;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;

    hex_pixel_fetch_scheduler #(.FRAME_W(96), .RD_LAT(RD_LAT), .RF_BASE(9216)) dut (
        .clk(clk), .rst(rst), .req(req),
        .cf_x_bus(cf_x_bus), .cf_y_bus(cf_y_bus), .rf_x_bus(rf_x_bus), .rf_y_bus(rf_y_bus),
        .busy(busy), .done(done), .cf_pix_bus(cf_pix_bus), .rf_pix_bus(rf_pix_bus),
        .oob_mask(oob_mask), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cx [7], cy [7], rx [7], ry [7];
    logic [14:0] exp_list [14];
    int          exp_n;
    logic [55:0] exp_cf, exp_rf;
    logic [13:0] exp_oob;

    logic        mp_v [RD_LAT];
    logic [14:0] mp_a [RD_LAT];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        iss;
        logic [14:0] a;
        iss = mem_rd && mem_gnt;
        a   = mem_addr;
        @(posedge clk);
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            mp_v[i] = mp_v[i-1];
            mp_a[i] = mp_a[i-1];
        end
        mp_v[0] = iss;
        mp_a[0] = a;
        mem_rdata = mp_v[RD_LAT-1] ? mp_a[RD_LAT-1][7:0] : 8'($urandom);
    endtask

    function automatic int pt_x(input int s);
        return (s < 7) ? cx[s] : rx[s-7];
    endfunction

    function automatic int pt_y(input int s);
        return (s < 7) ? cy[s] : ry[s-7];
    endfunction

    task automatic base_coords();
        for (int n = 0; n < 7; n++) begin
            cx[n] = 8 + 10 * n;
            cy[n] = 8 + n;
            rx[n] = 20 + 5 * n;
            ry[n] = 30 + 3 * n;
        end
    endtask

    task automatic apply_coords();
        for (int n = 0; n < 7; n++) begin
            cf_x_bus[7*n +: 7] = 7'(cx[n]);
            cf_y_bus[7*n +: 7] = 7'(cy[n]);
            rf_x_bus[7*n +: 7] = 7'(rx[n]);
            rf_y_bus[7*n +: 7] = 7'(ry[n]);
        end
    endtask

    task automatic build_exp(input int first);
        int a;
        logic [7:0] p;
        exp_n = 0;
        exp_oob = '0;
        for (int s = 0; s < 14; s++) begin
            a = pt_y(s) * 96 + pt_x(s) + ((s >= 7) ? 9216 : 0);
            if (pt_x(s) >= 96 || pt_y(s) >= 96) begin
                exp_oob[s] = 1'b1;
                p = 8'd0;
            end else begin
                p = a[7:0];
                if (s >= first) begin
                    exp_list[exp_n] = 15'(a);
                    exp_n++;
                end
            end
            if (s < 7) exp_cf[8*s +: 8] = p;
            else       exp_rf[8*(s-7) +: 8] = p;
        end
    endtask

    // One fetch; gmode 1 drops the grant on even cycles 2..14; abort_at>0 pulses rst at that cycle.
    task automatic run(input int gmode, input int abort_at, output int done_cyc, output int n_iss,
                       output int addr_bad, output int holds, output int hold_bad);
        int          k;
        logic [14:0] pa;
        logic        pl;
        done_cyc = -1; n_iss = 0; addr_bad = 0; holds = 0; hold_bad = 0;
        k = 0; pl = 1'b0; pa = '0;
        mem_gnt = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            mem_gnt = (gmode == 1 && c <= 14 && (c % 2) == 0) ? 1'b0 : 1'b1;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (mem_rd && pl) begin
                holds++;
                if (mem_addr !== pa) hold_bad++;
            end
            if (mem_rd && mem_gnt) begin
                if (k >= exp_n || mem_addr !== exp_list[k]) addr_bad++;
                k++;
                n_iss++;
            end
            pl = mem_rd && !mem_gnt;
            pa = mem_addr;
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                break;
            end
            tick();
        end
        mem_gnt = 1'b1;
    endtask

    int dc, ni, ab, ho, hb, ndone, nlow;
    logic [55:0] prev_cf, prev_rf;

    initial begin
        rst = 1'b1; req = 1'b0; mem_gnt = 1'b1; mem_rdata = 8'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            mp_v[i] = 1'b0;
            mp_a[i] = '0;
        end
        base_coords();
        apply_coords();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cf_pix", cf_pix_bus, 0);
        chk("rst_rf_pix", rf_pix_bus, 0);
        chk("rst_oob", oob_mask, 0);

        // Full grant, all points in frame.
        build_exp(0);
        run(0, 0, dc, ni, ab, ho, hb);
        $display("T1 full grant: done_cyc=%0d issues=%0d addr_bad=%0d", dc, ni, ab);
        chk("t1_done_cycle", dc, 17);
        chk("t1_issues", ni, 14);
        chk("t1_addr_seq", ab, 0);
        chk("t1_cf0_pix", cf_pix_bus[7:0], 8'h08);
        chk("t1_cf_pix", cf_pix_bus, exp_cf);
        chk("t1_rf_pix", rf_pix_bus, exp_rf);
        chk("t1_oob", oob_mask, 0);
        chk("t1_busy_at_done", busy, 1);
        prev_cf = cf_pix_bus;
        prev_rf = rf_pix_bus;
        tick();
        chk("t1_busy_after", busy, 0);
        chk("t1_done_pulse", done, 0);

`ifdef HEX_FETCH_CF_CACHE_EN
        // Same cf coordinates, new rf coordinates: only rf slots are fetched.
        for (int n = 0; n < 7; n++) rx[n] = rx[n] + 1;
        apply_coords();
        build_exp(7);
        run(0, 0, dc, ni, ab, ho, hb);
        $display("TC cache hit: done_cyc=%0d issues=%0d addr_bad=%0d", dc, ni, ab);
        chk("tc_done_cycle", dc, 10);
        chk("tc_issues", ni, 7);
        chk("tc_addr_seq", ab, 0);
        chk("tc_cf_kept", cf_pix_bus, prev_cf);
        chk("tc_rf_pix", rf_pix_bus, exp_rf);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        build_exp(0);
        run(0, 0, dc, ni, ab, ho, hb);
        $display("TC after rst: done_cyc=%0d issues=%0d", dc, ni);
        chk("tc_inval_done", dc, 17);
        chk("tc_inval_issues", ni, 14);
        chk("tc_inval_cf", cf_pix_bus, exp_cf);
        tick();
`else
        // Grant low on cycles 2,4,...,14.
        run(1, 0, dc, ni, ab, ho, hb);
        $display("T2 toggled grant: done_cyc=%0d issues=%0d holds=%0d hold_bad=%0d", dc, ni, ho, hb);
        chk("t2_done_cycle", dc, 24);
        chk("t2_issues", ni, 14);
        chk("t2_addr_seq", ab, 0);
        chk("t2_holds", ho, 7);
        chk("t2_hold_stable", hb, 0);
        chk("t2_cf_same", cf_pix_bus, prev_cf);
        chk("t2_rf_same", rf_pix_bus, prev_rf);
        tick();

        // rf point 3 x=100, cf point 5 y=96.
        rx[3] = 100;
        cy[5] = 96;
        apply_coords();
        build_exp(0);
        run(0, 0, dc, ni, ab, ho, hb);
        $display("T3 out of frame: done_cyc=%0d issues=%0d oob=%h", dc, ni, oob_mask);
        chk("t3_done_cycle", dc, 17);
        chk("t3_issues", ni, 12);
        chk("t3_addr_seq", ab, 0);
        chk("t3_oob", oob_mask, 14'h0420);
        chk("t3_cf5_zero", cf_pix_bus[47:40], 8'h00);
        chk("t3_rf3_zero", rf_pix_bus[31:24], 8'h00);
        chk("t3_cf_pix", cf_pix_bus, exp_cf);
        chk("t3_rf_pix", rf_pix_bus, exp_rf);
        tick();

        // Reset during ISSUE at cycle 9, request again at cycle 11.
        base_coords();
        for (int n = 0; n < 7; n++) ry[n] = ry[n] + 20;
        apply_coords();
        build_exp(0);
        run(0, 9, dc, ni, ab, ho, hb);
        $display("T4 abort: done_cyc=%0d issues_before_rst=%0d", dc, ni);
        chk("t4_no_done", dc, -1);
        chk("t4_idle_c10", busy, 0);
        tick();
        chk("t4_done_c11", done, 0);
        chk("t4_cf_clear", cf_pix_bus, 0);
        chk("t4_rf_clear", rf_pix_bus, 0);
        chk("t4_oob_clear", oob_mask, 0);
        run(0, 0, dc, ni, ab, ho, hb);
        $display("T4 reissue: done at T+%0d issues=%0d", dc + 11, ni);
        chk("t4_done_cycle", dc + 11, 28);
        chk("t4_issues", ni, 14);
        chk("t4_cf_pix", cf_pix_bus, exp_cf);
        chk("t4_rf_pix", rf_pix_bus, exp_rf);
        tick();

        // req held high: one acceptance per done, re-acceptance right after done.
        req = 1'b1;
        tick();
        ndone = 0;
        nlow = 0;
        for (int c = 1; c <= 17; c++) begin
            if (done) ndone++;
            if (!busy) nlow++;
            if (c < 17) tick();
        end
        $display("T6 req held: dones=%0d busy_low=%0d", ndone, nlow);
        chk("t6_one_done", ndone, 1);
        chk("t6_busy_held", nlow, 0);
        tick();
        chk("t6_idle_after_done", busy, 0);
        tick();
        chk("t6_reaccept", busy, 1);
        req = 1'b0;
        dc = -1;
        for (int c = 19; c <= 60; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            tick();
        end
        $display("T6 second fetch: done_cyc=%0d", dc);
        chk("t6_second_done", dc, 35);
        tick();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
